// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter: one XOR unit shared round-robin by NREQ requesters,
// with a LAT-cycle busy window and a response held until accepted.
module xor_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int CNTW  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_d,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [CNTW-1:0]           txn_count
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [IW:0]   NQ       = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LASTID   = IW'(NREQ-1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT-1);

  logic [1:0]       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] win_d;
  logic [IW:0]      idx;
  logic             found;
  logic             accept;

  // Search ptr, ptr+1, ... modulo NREQ for the first valid requester.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= NQ) idx = idx - NQ;
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
    if (found) grant[win] = 1'b1;
  end

  always_comb begin
    win_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win)
        win_d = req_a[i*WIDTH +: WIDTH] ^ req_b[i*WIDTH +: WIDTH];
    end
  end

  assign req_ready = (rst_n && state == IDLE && !flush) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_d     <= '0;
      busy      <= 1'b0;
      txn_count <= '0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (accept) begin
            rsp_id <= win;
            rsp_d  <= win_d;
            ptr    <= (win == LASTID) ? '0 : win + 1'b1;
            cnt    <= CNT_LOAD;
            state  <= BUSY;
            busy   <= 1'b1;
          end
        end
        state == BUSY: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        state == RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            if (txn_count != '1)
              txn_count <= txn_count + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
